// File: rtl/mc_controller.sv
// Purpose : multicycle RV32I control FSM driving datapath enables and mux selects.
// Latency : one state per cycle (lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5, lui 3 cycles).
// Backpr. : none; one instruction in flight, HALT is sticky until rst.
// Ports   : clk/rst (sync, active-high); opcode/funct3/funct7b5 from IR; zero/neg from ALU;
//           pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a, alu_src_b,
//           result_src, imm_src, alu_ctrl to the datapath; halted status.
module mc_controller #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       neg,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic [2:0] alu_ctrl,
  output logic       halted
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXER, S_EXEI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LINKJ, S_LUI, S_HALT
  } state_t;

  state_t state_q, state_d;

  // funct3/funct7b5 -> ALU op; sub_ok is low for immediates since there is no subi.
  function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub_ok);
    case (f3)
      3'b000:  alu_op = sub_ok ? ALU_SUB : ALU_ADD;
      3'b111:  alu_op = ALU_AND;
      3'b110:  alu_op = ALU_OR;
      3'b100:  alu_op = ALU_XOR;
      3'b010:  alu_op = ALU_SLT;
      default: alu_op = ALU_ADD;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXER;
          OP_I:              state_d = S_EXEI;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      // opcode[5] separates sw (0100011) from lw (0000011).
      S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXER:     state_d = S_ALUWB;
      S_EXEI:     state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      // JALR overwrites ALUOut with the target, so the link value is rebuilt in LINKJ.
      S_JALR:     state_d = S_LINKJ;
      S_LINKJ:    state_d = S_ALUWB;
      S_LUI:      state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Outputs are decoded from state_q rather than registered: BRANCH's pc_write
  // depends on the ALU flags of the same cycle. rst masks everything to zero.
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    imm_src    = IMM_I;
    alu_ctrl   = ALU_ADD;
    halted     = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          ir_write = 1'b1; pc_write = 1'b1;
          alu_src_b = 2'b10; result_src = 2'b10;
        end
        S_DECODE: begin
          alu_src_a = 2'b01; alu_src_b = 2'b01; imm_src = IMM_B;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10; alu_src_b = 2'b01;
          imm_src = opcode[5] ? IMM_S : IMM_I;
        end
        S_MEMREAD:  adr_src = 1'b1;
        S_MEMWB:    begin result_src = 2'b01; reg_write = 1'b1; end
        S_MEMWRITE: begin adr_src = 1'b1; mem_write = 1'b1; end
        S_EXER: begin
          alu_src_a = 2'b10; alu_ctrl = alu_op(funct3, funct7b5);
        end
        S_EXEI: begin
          alu_src_a = 2'b10; alu_src_b = 2'b01; alu_ctrl = alu_op(funct3, 1'b0);
        end
        S_ALUWB:    reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a = 2'b10; alu_ctrl = ALU_SUB;
          case (funct3)
            3'b000:  pc_write = zero;
            3'b001:  pc_write = !zero;
            3'b100:  pc_write = neg;
            3'b101:  pc_write = !neg;
            default: pc_write = 1'b0;
          endcase
        end
        S_JAL:  begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_write = 1'b1; end
        S_JALR: begin
          alu_src_a = 2'b10; alu_src_b = 2'b01; result_src = 2'b10; pc_write = 1'b1;
        end
        S_LINKJ: begin alu_src_a = 2'b01; alu_src_b = 2'b10; end
        S_LUI:   begin result_src = 2'b11; imm_src = IMM_U; reg_write = 1'b1; end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Purpose : scoreboard bench for mc_controller against an instruction-level control model.
// Latency : expected control words queued per cycle at issue; monitor checks each negedge.
// Backpr. : n/a; the monitor consumes one expected word every checked cycle.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5, zero, neg;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, halted;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src, alu_ctrl;

  mc_controller #(.ILLEGAL_HALT(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .neg(neg), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .imm_src(imm_src), .alu_ctrl(alu_ctrl), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, adr, memw, irw, regw;
    logic [1:0] a, b, res;
    logic [2:0] imm, alu;
    logic       hlt;
  } ctl_t;

  localparam logic [1:0] A_PC = 2'd0, A_OLD = 2'd1, A_RS1 = 2'd2;
  localparam logic [1:0] B_RS2 = 2'd0, B_IMM = 2'd1, B_4 = 2'd2;
  localparam logic [1:0] R_AOUT = 2'd0, R_DATA = 2'd1, R_ALU = 2'd2, R_IMM = 2'd3;
  localparam logic [2:0] I_I = 3'd0, I_S = 3'd1, I_B = 3'd2, I_U = 3'd4;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3, XOR_ = 3'd4, SLT = 3'd5;

  ctl_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   chk_en = 1'b0;
  logic [6:0] op_tab [0:7];

  function automatic ctl_t w(input logic pcw, adr, memw, irw, regw,
                             input logic [1:0] a, b, res,
                             input logic [2:0] imm, alu, input logic hlt);
    ctl_t c;
    c.pcw = pcw; c.adr = adr; c.memw = memw; c.irw = irw; c.regw = regw;
    c.a = a; c.b = b; c.res = res; c.imm = imm; c.alu = alu; c.hlt = hlt;
    return c;
  endfunction

  // Arithmetic intent of funct3 for R/I instructions, as the ISA defines it.
  function automatic logic [2:0] arith(input logic [2:0] f3, input logic f7, input logic is_reg);
    if (f3 == 3'b000) return (is_reg && f7) ? SUB : ADD;
    if (f3 == 3'b111) return AND_;
    if (f3 == 3'b110) return OR_;
    if (f3 == 3'b100) return XOR_;
    if (f3 == 3'b010) return SLT;
    return ADD;
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic z, input logic n);
    if (f3 == 3'b000) return z;
    if (f3 == 3'b001) return !z;
    if (f3 == 3'b100) return n;
    if (f3 == 3'b101) return !n;
    return 1'b0;
  endfunction

  ctl_t zero_w, halt_w, wb_w;

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) exp_q.push_back(zero_w);
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issues one instruction: every instruction is fetch + decode followed by the
  // steps its class needs. abort_at >= 0 truncates it and applies a 2-cycle reset.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z, input logic n, input int abort_at);
    ctl_t seq[$];
    bit   illegal = 1'b0;
    opcode = op; funct3 = f3; funct7b5 = f7; zero = z; neg = n;
    seq.push_back(w(1, 0, 0, 1, 0, A_PC, B_4, R_ALU, I_I, ADD, 0));
    seq.push_back(w(0, 0, 0, 0, 0, A_OLD, B_IMM, R_AOUT, I_B, ADD, 0));
    case (op)
      7'b0000011: begin
        seq.push_back(w(0, 0, 0, 0, 0, A_RS1, B_IMM, R_AOUT, I_I, ADD, 0));
        seq.push_back(w(0, 1, 0, 0, 0, A_PC, B_RS2, R_AOUT, I_I, ADD, 0));
        seq.push_back(w(0, 0, 0, 0, 1, A_PC, B_RS2, R_DATA, I_I, ADD, 0));
      end
      7'b0100011: begin
        seq.push_back(w(0, 0, 0, 0, 0, A_RS1, B_IMM, R_AOUT, I_S, ADD, 0));
        seq.push_back(w(0, 1, 1, 0, 0, A_PC, B_RS2, R_AOUT, I_I, ADD, 0));
      end
      7'b0110011: begin
        seq.push_back(w(0, 0, 0, 0, 0, A_RS1, B_RS2, R_AOUT, I_I, arith(f3, f7, 1), 0));
        seq.push_back(wb_w);
      end
      7'b0010011: begin
        seq.push_back(w(0, 0, 0, 0, 0, A_RS1, B_IMM, R_AOUT, I_I, arith(f3, f7, 0), 0));
        seq.push_back(wb_w);
      end
      7'b1100011:
        seq.push_back(w(taken(f3, z, n), 0, 0, 0, 0, A_RS1, B_RS2, R_AOUT, I_I, SUB, 0));
      7'b1101111: begin
        seq.push_back(w(1, 0, 0, 0, 0, A_OLD, B_4, R_AOUT, I_I, ADD, 0));
        seq.push_back(wb_w);
      end
      7'b1100111: begin
        seq.push_back(w(1, 0, 0, 0, 0, A_RS1, B_IMM, R_ALU, I_I, ADD, 0));
        seq.push_back(w(0, 0, 0, 0, 0, A_OLD, B_4, R_AOUT, I_I, ADD, 0));
        seq.push_back(wb_w);
      end
      7'b0110111:
        seq.push_back(w(0, 0, 0, 0, 1, A_PC, B_RS2, R_IMM, I_U, ADD, 0));
      default: begin
        illegal = 1'b1;
        for (int i = 0; i < 12; i++) seq.push_back(halt_w);
      end
    endcase
    if (abort_at >= 0)
      while (seq.size() > abort_at) void'(seq.pop_back());
    foreach (seq[i]) exp_q.push_back(seq[i]);
    repeat (seq.size()) @(posedge clk);
    #1;
    if (abort_at >= 0 || illegal) do_reset(2);
  endtask

  // Monitor: one expected word per checked cycle, sampled away from posedge.
  initial begin
    ctl_t act, e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cyc++;
        act = w(pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a, alu_src_b,
                result_src, imm_src, alu_ctrl, halted);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL ctl_underflow cyc=%0d act=%h required=<no expected word>", cyc, act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_bad++;
            $display("FAIL ctl cyc=%0d op=%b f3=%b rst=%b act=%h required=%h",
                     cyc, opcode, funct3, rst, act, e);
          end
        end
      end
    end
  end

  initial begin
    logic [6:0] op;
    bit         legal;
    op_tab[0] = 7'b0000011; op_tab[1] = 7'b0100011; op_tab[2] = 7'b0110011;
    op_tab[3] = 7'b0010011; op_tab[4] = 7'b1100011; op_tab[5] = 7'b1101111;
    op_tab[6] = 7'b1100111; op_tab[7] = 7'b0110111;
    zero_w = w(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0);
    halt_w = w(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1);
    wb_w   = w(0, 0, 0, 0, 1, 2'd0, 2'd0, R_AOUT, 3'd0, 3'd0, 0);
    rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; neg = 1'b0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    do_reset(2);

    // Directed cases.
    run_instr(7'b0000011, 3'b010, 0, 0, 0, 4);   // lw abandoned by reset in MEMWB
    run_instr(7'b0000011, 3'b010, 0, 0, 0, -1);  // full lw
    run_instr(7'b0110011, 3'b000, 1, 0, 0, -1);  // sub
    run_instr(7'b1100011, 3'b001, 0, 1, 0, -1);  // bne, not taken
    run_instr(7'b1100011, 3'b001, 0, 0, 0, -1);  // bne, taken
    run_instr(7'b1100111, 3'b000, 0, 0, 0, -1);  // jalr
    run_instr(7'b0100011, 3'b010, 0, 0, 0, -1);  // sw
    run_instr(7'b0110111, 3'b000, 0, 0, 0, -1);  // lui
    run_instr(7'b1111111, 3'b000, 0, 0, 0, -1);  // illegal -> HALT, then reset
    run_instr(7'b0010011, 3'b000, 1, 0, 0, -1);  // addi with funct7b5 set: still add

    // Random mix, with occasional illegal opcodes.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        do begin
          op = 7'($urandom);
          legal = 1'b0;
          for (int j = 0; j < 8; j++) if (op_tab[j] == op) legal = 1'b1;
        end while (legal);
      end else begin
        op = op_tab[$urandom_range(0, 7)];
      end
      run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), -1);
    end

    chk_en = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_expected act=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
